id_ex_stage: RTL

Decode-to-execute pipeline register for the RV32 pipeline: latches one decoded instruction (operands, ALU control, destination) and presents it to the ALU with a valid/ready handshake. Resolves RAW hazards against the EX/MEM and MEM/WB stages by operand forwarding or, when forwarding is compiled out, by stalling decode. Sits directly upstream of `alu`; its `o_op1`, `o_op2`, `o_aluSel`, `o_sign` and `o_shift` outputs drive the ALU's `i_1`, `i_2`, `aluSel`, `sign` and `shift` inputs.

---
 rtl/rv32_pipe_pkg.sv | 39 +++
 rtl/id_ex_stage_operand_fwd.sv | 57 +++++
 rtl/id_ex_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pipe_pkg
// Shared definitions for the RV32 pipeline stages:
//   XLEN, RW          - datapath and register-address widths
//   ALU_*             - ALU select encodings driven on aluSel
//   fwd_sel_e         - operand forwarding source select
//   src_hit()         - "does this producer stage write this source register"
// ---------------------------------------------------------------------------
package rv32_pipe_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_XOR   = 4'd2;
    localparam logic [3:0] ALU_ADD   = 4'd3;
    localparam logic [3:0] ALU_SUB   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_PASS2 = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_SLA   = 4'd10;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_MWB  = 2'd2
    } fwd_sel_e;

    // A producer hits a source when it writes that register; x0 never hits.
    function automatic logic src_hit(input logic [RW-1:0] src,
                                     input logic [RW-1:0] rd,
                                     input logic          we);
        return we && (rd == src) && (src != {RW{1'b0}});
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// ---------------------------------------------------------------------------
// operand_fwd
// Hit detection and 3:1 forwarding mux for one ALU source operand.
// Priority: EX/MEM > MEM/WB > stored register data. x0 always yields 0.
// Ports:
//   src_addr, src_data            - stored source index and data
//   exm_rd, exm_we, exm_data      - EX/MEM producer
//   mwb_rd, mwb_we, mwb_data      - MEM/WB producer
//   sel                           - which source won (FWD_NONE on no hit)
//   fwd_data                      - resulting operand value
// ---------------------------------------------------------------------------
module operand_fwd
    import rv32_pipe_pkg::*;
#(
    parameter int XLEN = rv32_pipe_pkg::XLEN,
    parameter int RW   = rv32_pipe_pkg::RW
) (
    input  logic [RW-1:0]   src_addr,
    input  logic [XLEN-1:0] src_data,
    input  logic [RW-1:0]   exm_rd,
    input  logic            exm_we,
    input  logic [XLEN-1:0] exm_data,
    input  logic [RW-1:0]   mwb_rd,
    input  logic            mwb_we,
    input  logic [XLEN-1:0] mwb_data,
    output fwd_sel_e        sel,
    output logic [XLEN-1:0] fwd_data
);

    // Pick the youngest producer that writes this source.
    always_comb begin
        sel = FWD_NONE;
        if (src_hit(src_addr, exm_rd, exm_we)) begin
            sel = FWD_EXM;
        end else if (src_hit(src_addr, mwb_rd, mwb_we)) begin
            sel = FWD_MWB;
        end else begin
            sel = FWD_NONE;
        end
    end

    // Operand mux; x0 is forced to zero whatever the stored data says.
    always_comb begin
        fwd_data = {XLEN{1'b0}};
        if (src_addr == {RW{1'b0}}) begin
            fwd_data = {XLEN{1'b0}};
        end else begin
            case (sel)
                FWD_EXM:  fwd_data = exm_data;
                FWD_MWB:  fwd_data = mwb_data;
                FWD_NONE: fwd_data = src_data;
                default:  fwd_data = src_data;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register. Holds one decoded instruction and
// presents it to the ALU with a valid/ready handshake. RAW hazards against
// EX/MEM and MEM/WB are resolved by forwarding (ID_EX_FWD_EN defined) or by
// stalling decode (ID_EX_FWD_EN undefined, the default build).
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   i_valid / o_ready              - decode handshake
//   i_rs*_addr, i_rs*_data, i_imm, i_use_imm, i_rd_addr, i_rd_we,
//   i_aluSel, i_sign, i_shift, i_pc - decoded instruction fields
//   i_flush                        - squash held/incoming instruction
//   i_ex_ready                     - execute consumes o_* this cycle
//   i_exm_*, i_mwb_*               - producer stages for forwarding/hazards
//   o_valid, o_op1, o_op2, o_aluSel, o_sign, o_shift, o_rd_addr, o_rd_we,
//   o_pc                           - held instruction towards the ALU
// Configuration macro: ID_EX_FWD_EN
// ---------------------------------------------------------------------------
module id_ex_stage
    import rv32_pipe_pkg::*;
#(
    parameter int XLEN = rv32_pipe_pkg::XLEN,
    parameter int RW   = rv32_pipe_pkg::RW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [RW-1:0]   i_rs1_addr,
    input  logic [RW-1:0]   i_rs2_addr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_use_imm,
    input  logic [RW-1:0]   i_rd_addr,
    input  logic            i_rd_we,
    input  logic [3:0]      i_aluSel,
    input  logic            i_sign,
    input  logic            i_shift,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    input  logic [RW-1:0]   i_exm_rd,
    input  logic            i_exm_we,
    input  logic [XLEN-1:0] i_exm_data,
    input  logic [RW-1:0]   i_mwb_rd,
    input  logic            i_mwb_we,
    input  logic [XLEN-1:0] i_mwb_data,
    output logic            o_valid,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic [3:0]      o_aluSel,
    output logic            o_sign,
    output logic            o_shift,
    output logic [RW-1:0]   o_rd_addr,
    output logic            o_rd_we,
    output logic [XLEN-1:0] o_pc
);

    logic            valid_r;
    logic [RW-1:0]   rs1_addr_r;
    logic [RW-1:0]   rs2_addr_r;
    logic [XLEN-1:0] rs1_data_r;
    logic [XLEN-1:0] rs2_data_r;
    logic [XLEN-1:0] imm_r;
    logic            use_imm_r;
    logic [RW-1:0]   rd_addr_r;
    logic            rd_we_r;
    logic [3:0]      alu_sel_r;
    logic            sign_r;
    logic            shift_r;
    logic [XLEN-1:0] pc_r;

    logic            exm_we_s;
    logic            mwb_we_s;
    logic            hazard_s;
    logic            ready_s;
    logic            accept_s;
    fwd_sel_e        sel1_s;
    fwd_sel_e        sel2_s;
    logic [XLEN-1:0] fwd1_s;
    logic [XLEN-1:0] fwd2_s;

`ifdef ID_EX_FWD_EN
    // Forwarding build: producers feed the operand muxes, decode never stalls.
    assign exm_we_s = i_exm_we;
    assign mwb_we_s = i_mwb_we;
    assign hazard_s = 1'b0;
`else
    // Stall build: muxes only ever select stored data (no producer enabled),
    // so both hold refresh and forwarding are inert.
    assign exm_we_s = 1'b0;
    assign mwb_we_s = 1'b0;

    // Stall decode while any in-flight producer still owes an incoming source.
    always_comb begin
        logic rs1_hit_s;
        logic rs2_hit_s;
        rs1_hit_s = src_hit(i_rs1_addr, rd_addr_r, valid_r & rd_we_r) |
                    src_hit(i_rs1_addr, i_exm_rd, i_exm_we) |
                    src_hit(i_rs1_addr, i_mwb_rd, i_mwb_we);
        rs2_hit_s = src_hit(i_rs2_addr, rd_addr_r, valid_r & rd_we_r) |
                    src_hit(i_rs2_addr, i_exm_rd, i_exm_we) |
                    src_hit(i_rs2_addr, i_mwb_rd, i_mwb_we);
        hazard_s  = rs1_hit_s | (rs2_hit_s & ~i_use_imm);
    end
`endif

    assign ready_s  = (~valid_r | i_ex_ready) & ~hazard_s;
    assign accept_s = i_valid & ready_s;

    operand_fwd #(.XLEN(XLEN), .RW(RW)) u_fwd_rs1 (
        .src_addr (rs1_addr_r),
        .src_data (rs1_data_r),
        .exm_rd   (i_exm_rd),
        .exm_we   (exm_we_s),
        .exm_data (i_exm_data),
        .mwb_rd   (i_mwb_rd),
        .mwb_we   (mwb_we_s),
        .mwb_data (i_mwb_data),
        .sel      (sel1_s),
        .fwd_data (fwd1_s)
    );

    operand_fwd #(.XLEN(XLEN), .RW(RW)) u_fwd_rs2 (
        .src_addr (rs2_addr_r),
        .src_data (rs2_data_r),
        .exm_rd   (i_exm_rd),
        .exm_we   (exm_we_s),
        .exm_data (i_exm_data),
        .mwb_rd   (i_mwb_rd),
        .mwb_we   (mwb_we_s),
        .mwb_data (i_mwb_data),
        .sel      (sel2_s),
        .fwd_data (fwd2_s)
    );

    // Pipeline register: flush beats accept; accept with consume replaces;
    // while held, refresh stored operands so a retiring result is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            rs1_addr_r <= {RW{1'b0}};
            rs2_addr_r <= {RW{1'b0}};
            rs1_data_r <= {XLEN{1'b0}};
            rs2_data_r <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
            use_imm_r  <= 1'b0;
            rd_addr_r  <= {RW{1'b0}};
            rd_we_r    <= 1'b0;
            alu_sel_r  <= 4'd0;
            sign_r     <= 1'b0;
            shift_r    <= 1'b0;
            pc_r       <= {XLEN{1'b0}};
        end else if (i_flush) begin
            valid_r <= 1'b0;
            rd_we_r <= 1'b0;
        end else if (accept_s) begin
            valid_r    <= 1'b1;
            rs1_addr_r <= i_rs1_addr;
            rs2_addr_r <= i_rs2_addr;
            rs1_data_r <= i_rs1_data;
            rs2_data_r <= i_rs2_data;
            imm_r      <= i_imm;
            use_imm_r  <= i_use_imm;
            rd_addr_r  <= i_rd_addr;
            rd_we_r    <= i_rd_we;
            alu_sel_r  <= i_aluSel;
            sign_r     <= i_sign;
            shift_r    <= i_shift;
            pc_r       <= i_pc;
        end else if (valid_r && i_ex_ready) begin
            valid_r <= 1'b0;
        end else if (valid_r) begin
            if (sel1_s != FWD_NONE) begin
                rs1_data_r <= fwd1_s;
            end
            if (sel2_s != FWD_NONE) begin
                rs2_data_r <= fwd2_s;
            end
        end
    end

    // Second ALU operand: immediate or (forwarded) rs2.
    always_comb begin
        o_op2 = {XLEN{1'b0}};
        if (use_imm_r) begin
            o_op2 = imm_r;
        end else begin
            o_op2 = fwd2_s;
        end
    end

    assign o_ready   = ready_s;
    assign o_valid   = valid_r;
    assign o_op1     = fwd1_s;
    assign o_aluSel  = alu_sel_r;
    assign o_sign    = sign_r;
    assign o_shift   = shift_r;
    assign o_rd_addr = rd_addr_r;
    assign o_rd_we   = rd_we_r;
    assign o_pc      = pc_r;

endmodule
